tff_counter: RTL



---
 rtl/tff_pkg.sv | 11 +
 rtl/tff_cell.sv | 12 +
 rtl/tff_counter.sv | 64 ++++++
 3 files changed

// File: rtl/tff_pkg.sv
// tff_pkg: shared direction constants and parameter legality check for the T flip-flop counter library.
package tff_pkg;
    localparam logic TFF_DIR_DOWN = 1'b0;
    localparam logic TFF_DIR_UP   = 1'b1;

    function automatic bit tff_width_t(input int width, input longint unsigned modulus,
                                       input longint unsigned rst_val);
        return width >= 2 && width <= 32 && modulus >= 64'd2 &&
               modulus <= (64'd1 << width) && rst_val < modulus;
    endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop stage with asynchronous active-low reset to a per-bit value.
module tff_cell (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    input  logic rst_val,
    output logic q
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) q <= rst_val;
        else if (t) q <= ~q;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: up/down modulo counter built from T stages with load, clamp, tc and wrap pulse.
// Define TFF_CNT_SAT_EN to saturate at the boundaries instead of wrapping.
module tff_counter
    import tff_pkg::*;
#(
    parameter int                WIDTH   = 8,
    parameter longint unsigned   MODULUS = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    if (!tff_width_t(WIDTH, MODULUS, 64'(RST_VAL))) begin : g_bad
        $error("tff_counter: illegal WIDTH/MODULUS/RST_VAL");
    end

    logic [WIDTH-1:0] inc_t, dec_t, term_t, load_c, t;
    logic             wrap_d;

    assign inc_t[0] = 1'b1;
    assign dec_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_t
        assign inc_t[i] = &q[i-1:0];
        assign dec_t[i] = ~|q[i-1:0];
    end

    assign load_c = load_val > MAX ? MAX : load_val;
    assign tc     = en & ~load & ((up == TFF_DIR_UP) ? q == MAX : q == '0);

`ifdef TFF_CNT_SAT_EN
    assign term_t = '0;
    assign wrap_d = 1'b0;
`else
    // Jump straight to the wrap target so non-power-of-two moduli work.
    assign term_t = q ^ ((up == TFF_DIR_UP) ? '0 : MAX);
    assign wrap_d = tc;
`endif

    assign t = load ? q ^ load_c :
               en   ? (tc ? term_t : (up == TFF_DIR_UP) ? inc_t : dec_t) : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk    (clk),
            .rstn   (rstn),
            .t      (t[i]),
            .rst_val(RST_VAL[i]),
            .q      (q[i])
        );
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) wrapped <= 1'b0;
        else wrapped <= wrap_d;
endmodule
